// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
// Microcoded control unit for the 8-bit bus CPU. A T-state counter steps
// through fetch (T0/T1) and opcode-dependent execute steps (T2..T5). The
// control word is a combinational decode of the current T-state, the opcode
// held by the instruction register and (in T2 only) the ALU flags; the
// datapath samples it on the next rising clock edge.
//
// This block is the sole owner of every bus enable and register load strobe,
// so each step lowers at most one bus-driving enable
// (n_ep, n_ce, n_ei, n_ea, n_eu).
// ----------------------------------------------------------------------------
module control_sequencer #(
   parameter bit EARLY_END = 1'b1   // 1: return to T0 after the last micro-step
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  opcode,
   input  logic        carry_flag,
   input  logic        zero_flag,
   output logic [14:0] ctrl,
   output logic [2:0]  stage,
   output logic        halted
);

   // ------------------------------------------------------------------------
   // Control word bit positions
   // ------------------------------------------------------------------------
   localparam int CP   = 0;   // PC increment, active-high
   localparam int N_EP = 1;   // PC to bus
   localparam int N_LP = 2;   // PC load
   localparam int N_LM = 3;   // MAR load
   localparam int N_CE = 4;   // RAM to bus
   localparam int N_WE = 5;   // RAM write
   localparam int N_LI = 6;   // IR load
   localparam int N_EI = 7;   // IR operand to bus
   localparam int N_LA = 8;   // A load
   localparam int N_EA = 9;   // A to bus
   localparam int SU   = 10;  // ALU subtract, active-high
   localparam int N_EU = 11;  // ALU to bus
   localparam int N_LB = 12;  // B load
   localparam int N_LO = 13;  // output register load
   localparam int LF   = 14;  // flags load, active-high

   // All active-low strobes deasserted, active-high strobes low.
   localparam logic [14:0] IDLE_WORD = 15'h3BFE;

   // ------------------------------------------------------------------------
   // Opcodes
   // ------------------------------------------------------------------------
   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_STA = 4'h3;
   localparam logic [3:0] OP_LDI = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JC  = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Last legal T-state index; 6 and 7 are never entered in normal operation.
   localparam logic [2:0] STAGE_MAX = 3'd5;

   // Index of the final micro-step of each instruction (length - 1).
   function automatic logic [2:0] instr_last_stage(input logic [3:0] op);
      logic [2:0] last;
      case (op)
         OP_LDA:  last = 3'd3;
         OP_ADD:  last = 3'd4;
         OP_SUB:  last = 3'd4;
         OP_STA:  last = 3'd3;
         default: last = 3'd2;   // LDI, JMP, JC, JZ, OUT, HLT and NOPs
      endcase
      return last;
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [2:0]  stage_q;
   logic [2:0]  stage_d;
   logic        halted_q;
   logic        halted_d;
   logic [2:0]  last_stage_s;
   logic [14:0] ctrl_s;

   // State register: T-state counter and sticky halt flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q  <= 3'd0;
         halted_q <= 1'b0;
      end else begin
         stage_q  <= stage_d;
         halted_q <= halted_d;
      end
   end

   // Final T-state for the current instruction: its own length or always T5.
   always_comb begin
      last_stage_s = STAGE_MAX;
      if (EARLY_END) begin
         last_stage_s = instr_last_stage(opcode);
      end else begin
         last_stage_s = STAGE_MAX;
      end
   end

   // Next-state logic: advance, wrap to T0, or park at T0 once halted.
   always_comb begin
      stage_d  = stage_q;
      halted_d = halted_q;
      if (halted_q) begin
         stage_d  = 3'd0;
         halted_d = 1'b1;
      end else if (stage_q > STAGE_MAX) begin
         // Unreachable encodings recover to fetch.
         stage_d  = 3'd0;
         halted_d = 1'b0;
      end else if ((stage_q == 3'd2) && (opcode == OP_HLT)) begin
         stage_d  = 3'd0;
         halted_d = 1'b1;
      end else if (stage_q >= last_stage_s) begin
         // >= so an opcode change mid-instruction still returns to fetch.
         stage_d  = 3'd0;
         halted_d = 1'b0;
      end else begin
         stage_d  = stage_q + 3'd1;
         halted_d = 1'b0;
      end
   end

   // Output decode: control word from T-state, opcode and T2 flags.
   always_comb begin
      ctrl_s = IDLE_WORD;
      if (!rst_n || halted_q) begin
         // Reset shows IDLE immediately, without waiting for the flops.
         ctrl_s = IDLE_WORD;
      end else begin
         case (stage_q)
            3'd0: begin
               ctrl_s[N_EP] = 1'b0;
               ctrl_s[N_LM] = 1'b0;
            end
            3'd1: begin
               ctrl_s[N_CE] = 1'b0;
               ctrl_s[N_LI] = 1'b0;
               ctrl_s[CP]   = 1'b1;
            end
            3'd2: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     ctrl_s[N_EI] = 1'b0;
                     ctrl_s[N_LM] = 1'b0;
                  end
                  OP_LDI: begin
                     ctrl_s[N_EI] = 1'b0;
                     ctrl_s[N_LA] = 1'b0;
                  end
                  OP_JMP: begin
                     ctrl_s[N_EI] = 1'b0;
                     ctrl_s[N_LP] = 1'b0;
                  end
                  OP_JC: begin
                     if (carry_flag) begin
                        ctrl_s[N_EI] = 1'b0;
                        ctrl_s[N_LP] = 1'b0;
                     end else begin
                        ctrl_s = IDLE_WORD;
                     end
                  end
                  OP_JZ: begin
                     if (zero_flag) begin
                        ctrl_s[N_EI] = 1'b0;
                        ctrl_s[N_LP] = 1'b0;
                     end else begin
                        ctrl_s = IDLE_WORD;
                     end
                  end
                  OP_OUT: begin
                     ctrl_s[N_EA] = 1'b0;
                     ctrl_s[N_LO] = 1'b0;
                  end
                  default: begin
                     // HLT and NOPs: no strobes in T2.
                     ctrl_s = IDLE_WORD;
                  end
               endcase
            end
            3'd3: begin
               case (opcode)
                  OP_LDA: begin
                     ctrl_s[N_CE] = 1'b0;
                     ctrl_s[N_LA] = 1'b0;
                  end
                  OP_ADD, OP_SUB: begin
                     ctrl_s[N_CE] = 1'b0;
                     ctrl_s[N_LB] = 1'b0;
                  end
                  OP_STA: begin
                     ctrl_s[N_EA] = 1'b0;
                     ctrl_s[N_WE] = 1'b0;
                  end
                  default: begin
                     ctrl_s = IDLE_WORD;
                  end
               endcase
            end
            3'd4: begin
               case (opcode)
                  OP_ADD: begin
                     ctrl_s[N_EU] = 1'b0;
                     ctrl_s[N_LA] = 1'b0;
                     ctrl_s[LF]   = 1'b1;
                  end
                  OP_SUB: begin
                     ctrl_s[N_EU] = 1'b0;
                     ctrl_s[N_LA] = 1'b0;
                     ctrl_s[LF]   = 1'b1;
                     ctrl_s[SU]   = 1'b1;
                  end
                  default: begin
                     ctrl_s = IDLE_WORD;
                  end
               endcase
            end
            default: begin
               // T5 and the unreachable encodings 6/7 carry no strobes.
               ctrl_s = IDLE_WORD;
            end
         endcase
      end
   end

   assign ctrl   = ctrl_s;
   assign stage  = stage_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// Testbench for control_sequencer. Two instances share inputs: one with
// EARLY_END = 1 and one with EARLY_END = 0. Expected T-state/control-word
// items are queued per instruction and compared cycle by cycle.
// ----------------------------------------------------------------------------
module tb_control_sequencer;

   localparam logic [14:0] IDLE = 15'h3BFE;

   logic        clk;
   logic        rst_n;
   logic [3:0]  opcode;
   logic        carry_flag;
   logic        zero_flag;
   logic [14:0] ctrl1;
   logic [2:0]  stage1;
   logic        halted1;
   logic [14:0] ctrl0;
   logic [2:0]  stage0;
   logic        halted0;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic        c;
      logic        z;
      logic [2:0]  st;
      logic [14:0] word;
      logic        hlt;
   } item_t;

   item_t sb_q[$];

   control_sequencer #(.EARLY_END(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .carry_flag(carry_flag),
      .zero_flag(zero_flag), .ctrl(ctrl1), .stage(stage1), .halted(halted1)
   );

   control_sequencer #(.EARLY_END(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .carry_flag(carry_flag),
      .zero_flag(zero_flag), .ctrl(ctrl0), .stage(stage0), .halted(halted0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction length in T-states.
   function automatic int len_of(input logic [3:0] op);
      case (op)
         4'h0:       return 4;
         4'h1, 4'h2: return 5;
         4'h3:       return 4;
         default:    return 3;
      endcase
   endfunction

   // Expected control word, hand-encoded from the bit map.
   function automatic logic [14:0] exp_word(input logic [3:0] op, input int st,
                                            input logic c, input logic z);
      if (st == 0) return 15'h3BF4;
      if (st == 1) return 15'h3BAF;
      if (st >= len_of(op)) return IDLE;
      case (op)
         4'h0: return (st == 2) ? 15'h3B76 : 15'h3AEE;
         4'h1: return (st == 2) ? 15'h3B76 : ((st == 3) ? 15'h2BEE : 15'h72FE);
         4'h2: return (st == 2) ? 15'h3B76 : ((st == 3) ? 15'h2BEE : 15'h76FE);
         4'h3: return (st == 2) ? 15'h3B76 : 15'h39DE;
         4'h4: return 15'h3A7E;
         4'h5: return 15'h3B7A;
         4'h6: return c ? 15'h3B7A : IDLE;
         4'h7: return z ? 15'h3B7A : IDLE;
         4'hE: return 15'h19FE;
         default: return IDLE;
      endcase
   endfunction

   // Queue one instruction; flags outside T2 are randomised to show they are ignored.
   task automatic push_instr(input logic [3:0] op, input logic c, input logic z,
                             input bit early);
      item_t it;
      int n;
      n = early ? len_of(op) : 6;
      for (int st = 0; st < n; st++) begin
         it.op   = op;
         it.c    = (st == 2) ? c : 1'($urandom_range(1, 0));
         it.z    = (st == 2) ? z : 1'($urandom_range(1, 0));
         it.st   = 3'(st);
         it.word = exp_word(op, st, c, z);
         it.hlt  = 1'b0;
         sb_q.push_back(it);
      end
   endtask

   // Queue cycles expected while halted: stage 0, IDLE word, halted high.
   task automatic push_halted(input int cycles);
      item_t it;
      for (int i = 0; i < cycles; i++) begin
         it.op   = 4'($urandom_range(15, 0));
         it.c    = 1'($urandom_range(1, 0));
         it.z    = 1'($urandom_range(1, 0));
         it.st   = 3'd0;
         it.word = IDLE;
         it.hlt  = 1'b1;
         sb_q.push_back(it);
      end
   endtask

   // Drain the scoreboard: drive each item at the negedge, compare, step a clock.
   task automatic run_sb(input bit use0, input string tag);
      item_t it;
      logic [14:0] a_c;
      logic [2:0]  a_s;
      logic        a_h;
      while (sb_q.size() != 0) begin
         it = sb_q.pop_front();
         opcode     = it.op;
         carry_flag = it.c;
         zero_flag  = it.z;
         #1;
         a_c = use0 ? ctrl0   : ctrl1;
         a_s = use0 ? stage0  : stage1;
         a_h = use0 ? halted0 : halted1;
         total++;
         if (a_s !== it.st) begin
            bad++;
            $display("FAIL %s_stage op=%h got=%0d want=%0d", tag, it.op, a_s, it.st);
         end
         total++;
         if (a_c !== it.word) begin
            bad++;
            $display("FAIL %s_ctrl op=%h st=%0d got=%h want=%h", tag, it.op, it.st, a_c, it.word);
         end
         total++;
         if (a_h !== it.hlt) begin
            bad++;
            $display("FAIL %s_halted op=%h st=%0d got=%b want=%b", tag, it.op, it.st, a_h, it.hlt);
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Pulse reset for one cycle and return just after the following negedge.
   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (stage1 !== 3'd0 || ctrl1 !== IDLE || halted1 !== 1'b0) begin
         bad++;
         $display("FAIL reset_e1 got st=%0d ctrl=%h h=%b want st=0 ctrl=3bfe h=0", stage1, ctrl1, halted1);
      end
      total++;
      if (stage0 !== 3'd0 || ctrl0 !== IDLE || halted0 !== 1'b0) begin
         bad++;
         $display("FAIL reset_e0 got st=%0d ctrl=%h h=%b want st=0 ctrl=3bfe h=0", stage0, ctrl0, halted0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (ctrl1 !== 15'h3BF4) begin
         bad++;
         $display("FAIL reset_release_t0 got=%h want=3bf4", ctrl1);
      end
      @(negedge clk);
      // The first posedge after release moves into T1.
      total++;
      if (stage1 !== 3'd1) begin
         bad++;
         $display("FAIL reset_first_edge got=%0d want=1", stage1);
      end
      pulse_reset();
      @(negedge clk);
      pulse_reset();
   endtask

   task automatic test_single_instrs();
      logic [3:0] ops [0:9];
      ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hE, 4'h8, 4'h9, 4'hD};
      for (int i = 0; i < 10; i++) begin
         push_instr(ops[i], 1'b0, 1'b0, 1'b1);
         run_sb(1'b0, "instr");
      end
   endtask

   task automatic test_cond_jumps();
      push_instr(4'h6, 1'b0, 1'b1, 1'b1);
      push_instr(4'h6, 1'b1, 1'b0, 1'b1);
      push_instr(4'h7, 1'b1, 1'b0, 1'b1);
      push_instr(4'h7, 1'b0, 1'b1, 1'b1);
      run_sb(1'b0, "jump");
   endtask

   task automatic test_back_to_back();
      push_instr(4'h4, 1'b0, 1'b0, 1'b1);
      push_instr(4'h1, 1'b0, 1'b0, 1'b1);
      push_instr(4'h2, 1'b1, 1'b1, 1'b1);
      push_instr(4'h3, 1'b0, 1'b0, 1'b1);
      push_instr(4'hE, 1'b0, 1'b0, 1'b1);
      push_instr(4'h7, 1'b0, 1'b1, 1'b1);
      run_sb(1'b0, "b2b");
   endtask

   task automatic test_reset_mid();
      opcode = 4'h1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      total++;
      if (stage1 !== 3'd3) begin
         bad++;
         $display("FAIL midreset_setup got=%0d want=3", stage1);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (stage1 !== 3'd0 || ctrl1 !== IDLE) begin
         bad++;
         $display("FAIL midreset_async got st=%0d ctrl=%h want st=0 ctrl=3bfe", stage1, ctrl1);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (ctrl1 !== 15'h3BF4) begin
         bad++;
         $display("FAIL midreset_t0 got=%h want=3bf4", ctrl1);
      end
      @(negedge clk);
      pulse_reset();
   endtask

   task automatic test_halt();
      push_instr(4'hF, 1'b0, 1'b0, 1'b1);
      push_halted(20);
      run_sb(1'b0, "halt");
      rst_n = 1'b0;
      #1;
      total++;
      if (halted1 !== 1'b0 || ctrl1 !== IDLE) begin
         bad++;
         $display("FAIL halt_clear got h=%b ctrl=%h want h=0 ctrl=3bfe", halted1, ctrl1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      push_instr(4'h4, 1'b0, 1'b0, 1'b1);
      run_sb(1'b0, "halt_resume");
   endtask

   task automatic test_early_end0();
      pulse_reset();
      push_instr(4'h9, 1'b0, 1'b0, 1'b0);
      push_instr(4'h1, 1'b0, 1'b0, 1'b0);
      push_instr(4'h6, 1'b1, 1'b0, 1'b0);
      push_instr(4'h0, 1'b0, 1'b0, 1'b0);
      run_sb(1'b1, "ee0");
   endtask

   initial begin
      test_reset();
      test_single_instrs();
      test_cond_jumps();
      test_back_to_back();
      test_reset_mid();
      test_halt();
      test_early_end0();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
